// File: rtl/io_port_ctrl.sv
// I/O-mapped port responder: CPU writes to the data register fill a TX FIFO drained by a
// valid/ready device, device pushes fill an RX FIFO read back through the same register.
module io_port_ctrl #(
    parameter int          DW        = 16,
    parameter int          TX_DEPTH  = 4,
    parameter int          RX_DEPTH  = 4,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iom_in,
    input  logic          wen_in,
    input  logic [15:0]   addr_in,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_valid,
    output logic          rx_ready
);

    localparam int TPW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int RPW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam logic [15:0]    STAT_ADDR   = BASE_ADDR + 16'd1;
    localparam logic [TPW-1:0] TX_LAST     = TPW'(TX_DEPTH - 1);
    localparam logic [RPW-1:0] RX_LAST     = RPW'(RX_DEPTH - 1);
    localparam logic [3:0]     TX_FULL_CNT = 4'(TX_DEPTH);
    localparam logic [3:0]     RX_FULL_CNT = 4'(RX_DEPTH);

    logic [DW-1:0]  tx_mem_q [TX_DEPTH];
    logic [DW-1:0]  rx_mem_q [RX_DEPTH];
    logic [TPW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [RPW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [3:0]     tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic           ovf_q, ovf_d, unf_q, unf_d;

    logic hit_d, hit_s, tx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic ovf_set, unf_set, ovf_clr, unf_clr;
    logic [DW-1:0] status;

    function automatic logic [TPW-1:0] tx_inc(input logic [TPW-1:0] p);
        return (p == TX_LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [RPW-1:0] rx_inc(input logic [RPW-1:0] p);
        return (p == RX_LAST) ? '0 : p + 1'b1;
    endfunction

    assign hit_d    = iom_in && (addr_in == BASE_ADDR);
    assign hit_s    = iom_in && (addr_in == STAT_ADDR);
    assign tx_full  = (tx_cnt_q == TX_FULL_CNT);
    assign rx_empty = (rx_cnt_q == 4'd0);
    assign tx_valid = (tx_cnt_q != 4'd0);
    assign rx_ready = (rx_cnt_q != RX_FULL_CNT);
    assign tx_data  = tx_mem_q[tx_rp_q];

    // Push/pop decisions use start-of-cycle state only; a same-cycle pop never makes room.
    assign tx_push = hit_d && !wen_in && !tx_full;
    assign ovf_set = hit_d && !wen_in && tx_full;
    assign tx_pop  = tx_valid && tx_ready;
    assign rx_pop  = hit_d && wen_in && !rx_empty;
    assign unf_set = hit_d && wen_in && rx_empty;
    assign rx_push = rx_valid && rx_ready;
    assign ovf_clr = hit_s && !wen_in && data_in[2];
    assign unf_clr = hit_s && !wen_in && data_in[3];

    assign status = {{(DW-12){1'b0}}, rx_cnt_q, tx_cnt_q, unf_q, ovf_q, rx_empty, tx_full};

    // Read data is held at zero while reset is asserted.
    always_comb begin
        data_out = '0;
        if (rst_n && wen_in) begin
            if (hit_d && !rx_empty) data_out = rx_mem_q[rx_rp_q];
            else if (hit_s)         data_out = status;
        end
    end

    always_comb begin
        tx_wp_d  = tx_push ? tx_inc(tx_wp_q) : tx_wp_q;
        tx_rp_d  = tx_pop  ? tx_inc(tx_rp_q) : tx_rp_q;
        rx_wp_d  = rx_push ? rx_inc(rx_wp_q) : rx_wp_q;
        rx_rp_d  = rx_pop  ? rx_inc(rx_rp_q) : rx_rp_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + 4'd1;
        else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - 4'd1;
        rx_cnt_d = rx_cnt_q;
        if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + 4'd1;
        else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - 4'd1;
        ovf_d = ovf_set || (ovf_q && !ovf_clr);
        unf_d = unf_set || (unf_q && !unf_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is not reset: emptiness is tracked by the counts alone.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wp_q] <= data_in;
        if (rx_push) rx_mem_q[rx_wp_q] <= rx_data;
    end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Bench for io_port_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_io_port_ctrl;

    localparam int          DW   = 16;
    localparam int          TXD  = 4;
    localparam int          RXD  = 4;
    localparam logic [15:0] BASE = 16'h0300;
    localparam logic [15:0] STAT = BASE + 16'd1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          iom_in, wen_in;
    logic [15:0]   addr_in;
    logic [DW-1:0] data_in, data_out, tx_data, rx_data;
    logic          tx_valid, tx_ready, rx_valid, rx_ready;

    io_port_ctrl #(.DW(DW), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .iom_in(iom_in), .wen_in(wen_in), .addr_in(addr_in),
        .data_in(data_in), .data_out(data_out), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [15:0] tx_q[$];
    logic [15:0] rx_q[$];
    logic [15:0] seen[$];
    logic        m_ovf, m_unf;
    logic [15:0] last_do;
    logic        last_rr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] stat_model();
        return {4'h0, 4'(rx_q.size()), 4'(tx_q.size()), m_unf, m_ovf,
                rx_q.size() == 0, tx_q.size() == TXD};
    endfunction

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // One bus cycle: drive, check against the model, then advance the model at the edge.
    task automatic cyc(input logic iom, input logic wen, input logic [15:0] addr,
                       input logic [15:0] din, input logic txr, input logic rxv,
                       input logic [15:0] rxd);
        logic        rd_d, wr_d, rd_s, wr_s;
        logic [15:0] exp_do;
        int          txn, rxn;
        @(negedge clk);
        iom_in = iom; wen_in = wen; addr_in = addr; data_in = din;
        tx_ready = txr; rx_valid = rxv; rx_data = rxd;
        #1;
        txn  = tx_q.size();
        rxn  = rx_q.size();
        rd_d = iom && wen && addr == BASE;
        wr_d = iom && !wen && addr == BASE;
        rd_s = iom && wen && addr == STAT;
        wr_s = iom && !wen && addr == STAT;
        exp_do = 16'h0;
        if (rd_d && rxn > 0) exp_do = rx_q[0];
        if (rd_s) exp_do = stat_model();
        chk("data_out", data_out, exp_do);
        chk("tx_valid", tx_valid, txn > 0);
        if (txn > 0) chk("tx_data", tx_data, tx_q[0]);
        chk("rx_ready", rx_ready, rxn < RXD);
        last_do = data_out;
        last_rr = rx_ready;
        if (tx_valid && txr) seen.push_back(tx_data);
        @(posedge clk);
        m_ovf = (wr_d && txn == TXD) || (m_ovf && !(wr_s && din[2]));
        m_unf = (rd_d && rxn == 0)   || (m_unf && !(wr_s && din[3]));
        if (txn > 0 && txr) void'(tx_q.pop_front());
        if (wr_d && txn < TXD) tx_q.push_back(din);
        if (rd_d && rxn > 0) void'(rx_q.pop_front());
        if (rxv && rxn < RXD) rx_q.push_back(rxd);
    endtask

    initial begin
        logic [15:0] exp_seen[$];
        model_reset();
        rst_n = 1'b0;
        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            iom_in = 1'($urandom); wen_in = 1'($urandom); addr_in = 16'($urandom);
            data_in = 16'($urandom); tx_ready = 1'($urandom); rx_valid = 1'($urandom);
            rx_data = 16'($urandom);
            #1;
            chk("rst_tx_valid", tx_valid, 1'b0);
            chk("rst_rx_ready", rx_ready, 1'b1);
        end
        @(negedge clk);
        iom_in = 1'b1; wen_in = 1'b1; addr_in = STAT; rx_valid = 1'b0; tx_ready = 1'b0;
        #1;
        chk("rst_status", data_out, 16'h0000);
        @(negedge clk);
        iom_in = 1'b0;
        rst_n = 1'b1;
        cyc(1, 1, STAT, 0, 0, 0, 0);
        chk("idle_status", last_do, 16'h0002);

        // TX overflow: five writes with the device stalled
        for (int i = 1; i <= 5; i++) cyc(1, 0, BASE, 16'h00A0 + 16'(i), 0, 0, 0);
        cyc(1, 1, STAT, 0, 0, 0, 0);
        chk("ovf_status", last_do, 16'h0047);
        seen.delete();
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 1, 0, 0);
        exp_seen = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
        chk("tx_seen_cnt", seen.size(), 4);
        for (int i = 0; i < 4 && i < seen.size(); i++) chk("tx_seen", seen[i], exp_seen[i]);
        cyc(1, 0, STAT, 16'h0004, 0, 0, 0);

        // RX path and underflow
        cyc(0, 1, 0, 0, 0, 1, 16'h0011);
        cyc(0, 1, 0, 0, 0, 1, 16'h0022);
        cyc(1, 1, BASE, 0, 0, 0, 0);
        chk("rx_rd1", last_do, 16'h0011);
        cyc(1, 1, BASE, 0, 0, 0, 0);
        chk("rx_rd2", last_do, 16'h0022);
        cyc(1, 1, BASE, 0, 0, 0, 0);
        chk("rx_rd3", last_do, 16'h0000);
        cyc(1, 1, STAT, 0, 0, 0, 0);
        chk("unf_status", last_do, 16'h000A);

        // RX full back-pressure
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 1, 16'h0B00 + 16'(i));
        cyc(1, 1, BASE, 0, 0, 0, 0);
        chk("rx_full_rr", last_rr, 1'b0);
        chk("rx_full_rd", last_do, 16'h0B00);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("rx_rr_after", last_rr, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1, 1, BASE, 0, 0, 0, 0);
        cyc(1, 0, STAT, 16'h000C, 0, 0, 0);

        // Simultaneous TX push and pop at count 2
        seen.delete();
        cyc(1, 0, BASE, 16'h00B1, 0, 0, 0);
        cyc(1, 0, BASE, 16'h00B2, 0, 0, 0);
        cyc(1, 0, BASE, 16'h00B3, 1, 0, 0);
        cyc(1, 1, STAT, 0, 0, 0, 0);
        chk("tx_pp_status", last_do, 16'h0022);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 1, 0, 0);
        exp_seen = '{16'h00B1, 16'h00B2, 16'h00B3};
        chk("pp_seen_cnt", seen.size(), 3);
        for (int i = 0; i < 3 && i < seen.size(); i++) chk("pp_seen", seen[i], exp_seen[i]);

        // W1C of ovf only, then asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) cyc(1, 0, BASE, 16'h00C0 + 16'(i), 0, 0, 0);
        cyc(1, 1, BASE, 0, 0, 0, 0);
        cyc(1, 0, STAT, 16'h0004, 0, 0, 0);
        cyc(1, 1, STAT, 0, 0, 0, 0);
        chk("w1c_status", last_do, 16'h004B);
        for (int i = 0; i < 3; i++) cyc(1, 0, BASE, 16'h00D0 + 16'(i), 1, 1, 16'h0E00 + 16'(i));
        @(negedge clk);
        iom_in = 1'b1; wen_in = 1'b1; addr_in = STAT; tx_ready = 1'b0; rx_valid = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_tx_valid", tx_valid, 1'b0);
        chk("arst_rx_ready", rx_ready, 1'b1);
        chk("arst_data_out", data_out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 1, STAT, 0, 0, 0, 0);
        chk("post_rst_status", last_do, 16'h0002);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int          sel;
            logic [15:0] addr;
            logic        txr, rxv;
            sel  = int'($urandom_range(0, 9));
            addr = (sel < 4) ? BASE : (sel < 7) ? STAT : 16'($urandom);
            if (((i / 300) % 2) == 0) begin
                txr = ($urandom_range(0, 3) == 0);
                rxv = ($urandom_range(0, 3) != 0);
            end else begin
                txr = ($urandom_range(0, 3) != 0);
                rxv = ($urandom_range(0, 3) == 0);
            end
            cyc(($urandom_range(0, 7) != 0), 1'($urandom), addr, 16'($urandom),
                txr, rxv, 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
